// File: rtl/tracer_pkg.sv
// Shared definitions for the column tracer: pattern mode encodings, FSM states
// and the pattern LFSR constants.
package tracer_pkg;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACE,
    ST_STORE,
    ST_DONE
  } tracer_state_t;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAP_MASK)};
  endfunction

endpackage

// File: rtl/tracer_pattern_gen.sv
// Synthetic height source for the column tracer: owns the pattern LFSR and
// produces the clamped height, side flag and skip indication for the current column.
module tracer_pattern_gen
  import tracer_pkg::*;
#(
  parameter int          COL_W      = 10,
  parameter int          HEIGHT_W   = 8,
  parameter int          MAX_HEIGHT = 240,
  parameter int          RAMP_SHIFT = 2,
  parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_advance,
  input  logic [1:0]          i_mode,
  input  logic [HEIGHT_W-1:0] i_baseHeight,
  input  logic [COL_W-1:0]    i_column,
  output logic [HEIGHT_W-1:0] o_height,
  output logic                o_side,
  output logic                o_skip
);

  localparam int                  RAW_W   = HEIGHT_W + COL_W;
  localparam logic [RAW_W-1:0]    MAX_RAW = RAW_W'(MAX_HEIGHT);
  localparam logic [HEIGHT_W-1:0] MAX_H   = HEIGHT_W'(MAX_HEIGHT);
  localparam logic [HEIGHT_W-1:0] MIN_H   = HEIGHT_W'(1);

  logic [15:0]      r_lfsr;
  logic [RAW_W-1:0] w_raw;
  logic             w_side;

  // The LFSR survives frame restarts; only reset returns it to the seed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_advance) begin
      r_lfsr <= lfsrNext(r_lfsr);
    end
  end

  always_comb begin
    w_raw  = '0;
    w_side = 1'b0;
    case (i_mode)
      MODE_RAMP: begin
        w_raw  = RAW_W'(i_baseHeight) + RAW_W'(i_column >> RAMP_SHIFT);
        w_side = i_column[0];
      end
      MODE_LFSR: begin
        w_raw  = RAW_W'(r_lfsr[HEIGHT_W-1:0]);
        w_side = r_lfsr[15];
      end
      default: begin
        w_raw  = RAW_W'(i_baseHeight);
        w_side = i_baseHeight[0];
      end
    endcase
  end

  // Heights are kept inside 1..MAX_HEIGHT so the store never sees an empty column.
  always_comb begin
    if (w_raw == '0) begin
      o_height = MIN_H;
    end else if (w_raw > MAX_RAW) begin
      o_height = MAX_H;
    end else begin
      o_height = w_raw[HEIGHT_W-1:0];
    end
  end

  assign o_side = w_side;
  assign o_skip = (i_mode != MODE_RAMP) && (i_mode != MODE_LFSR) && (i_baseHeight == '0);

endmodule

// File: rtl/column_tracer.sv
// Per-column trace engine: walks every column of a frame, spends a fixed work
// period on each, and hands (column, side, height) to the result store over valid/ready.
module column_tracer
  import tracer_pkg::*;
#(
  parameter int          NUM_COLUMNS = 640,
  parameter int          COL_W       = 10,
  parameter int          HEIGHT_W    = 8,
  parameter int          MAX_HEIGHT  = 240,
  parameter int          WORK_CYCLES = 32,
  parameter int          RAMP_SHIFT  = 2,
  parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                frame_start,
  input  logic [1:0]          mode,
  input  logic [HEIGHT_W-1:0] debug_set_height,
  output logic                store_valid,
  input  logic                store_ready,
  output logic [COL_W-1:0]    column,
  output logic                side,
  output logic [HEIGHT_W-1:0] height,
  output logic                busy,
  output logic                frame_done
);

  localparam int               CNT_W      = (WORK_CYCLES > 1) ? $clog2(WORK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WORK_CYCLES - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLUMNS - 1);

  tracer_state_t       r_state;
  tracer_state_t       w_nextState;
  logic [CNT_W-1:0]    r_workCnt;
  logic [1:0]          r_mode;
  logic [COL_W-1:0]    r_column;
  logic                r_side;
  logic [HEIGHT_W-1:0] r_height;

  logic                w_start;
  logic                w_lastCol;
  logic                w_colDone;
  logic                w_skip;
  logic                w_patSide;
  logic [HEIGHT_W-1:0] w_patHeight;

  assign w_start   = enable && frame_start;
  assign w_lastCol = (r_column == LAST_COL);
  // A genuine TRACE exit: not pre-empted by disable or a restart in the same cycle.
  assign w_colDone = enable && !frame_start && (r_state == ST_TRACE) && (r_workCnt == '0);

  tracer_pattern_gen #(
    .COL_W      (COL_W),
    .HEIGHT_W   (HEIGHT_W),
    .MAX_HEIGHT (MAX_HEIGHT),
    .RAMP_SHIFT (RAMP_SHIFT),
    .LFSR_SEED  (LFSR_SEED)
  ) u_patternGen (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_advance    (w_colDone),
    .i_mode       (r_mode),
    .i_baseHeight (debug_set_height),
    .i_column     (r_column),
    .o_height     (w_patHeight),
    .o_side       (w_patSide),
    .o_skip       (w_skip)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Disable beats everything, then a restart request, then normal progression.
  always_comb begin
    w_nextState = r_state;
    if (!enable) begin
      w_nextState = ST_IDLE;
    end else if (frame_start) begin
      w_nextState = ST_TRACE;
    end else begin
      case (r_state)
        ST_IDLE: w_nextState = ST_IDLE;
        ST_TRACE: begin
          if (r_workCnt == '0) begin
            if (!w_skip) begin
              w_nextState = ST_STORE;
            end else if (w_lastCol) begin
              w_nextState = ST_DONE;
            end else begin
              w_nextState = ST_TRACE;
            end
          end
        end
        ST_STORE: begin
          if (store_ready) begin
            w_nextState = w_lastCol ? ST_DONE : ST_TRACE;
          end
        end
        ST_DONE: w_nextState = ST_IDLE;
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    store_valid = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      ST_TRACE: busy = 1'b1;
      ST_STORE: begin
        busy        = 1'b1;
        store_valid = 1'b1;
      end
      ST_DONE: frame_done = 1'b1;
      default: ;
    endcase
  end

  // Result registers only change at TRACE exit, so they stay frozen through a stalled STORE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_workCnt <= '0;
      r_mode    <= MODE_FIXED;
      r_column  <= '0;
      r_side    <= 1'b0;
      r_height  <= '0;
    end else if (w_start) begin
      r_workCnt <= CNT_RELOAD;
      r_mode    <= mode;
      r_column  <= '0;
    end else if (enable) begin
      case (r_state)
        ST_TRACE: begin
          if (r_workCnt != '0) begin
            r_workCnt <= r_workCnt - CNT_W'(1);
          end else if (w_skip) begin
            if (!w_lastCol) begin
              r_column  <= r_column + COL_W'(1);
              r_workCnt <= CNT_RELOAD;
            end
          end else begin
            r_side   <= w_patSide;
            r_height <= w_patHeight;
          end
        end
        ST_STORE: begin
          if (store_ready && !w_lastCol) begin
            r_column  <= r_column + COL_W'(1);
            r_workCnt <= CNT_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign column = r_column;
  assign side   = r_side;
  assign height = r_height;

endmodule

// File: tb/tb_column_tracer.sv
// Directed bench for column_tracer: expected stores are queued as each frame is
// launched and drained by a negedge monitor that compares every accepted result.
module tb_column_tracer;
  import tracer_pkg::*;

  localparam int          NUM_COLUMNS = 640;
  localparam int          COL_W       = 10;
  localparam int          HEIGHT_W    = 8;
  localparam int          MAX_HEIGHT  = 240;
  localparam int          WORK_CYCLES = 32;
  localparam int          RAMP_SHIFT  = 2;
  localparam logic [15:0] SEED        = 16'hACE1;
  localparam int          COL_PERIOD  = WORK_CYCLES + 1;

  typedef struct {
    int     col;
    int     side;
    int     height;
    longint cyc;
  } expect_t;

  logic                clk            = 1'b0;
  logic                reset_n        = 1'b0;
  logic                enable         = 1'b0;
  logic                frame_start    = 1'b0;
  logic [1:0]          mode           = 2'd0;
  logic [HEIGHT_W-1:0] debugSetHeight = '0;
  logic                store_ready    = 1'b0;
  logic                store_valid;
  logic [COL_W-1:0]    column;
  logic                side;
  logic [HEIGHT_W-1:0] height;
  logic                busy;
  logic                frame_done;

  longint  cyc        = 0;
  int      checkCount = 0;
  int      passCount  = 0;
  int      failCount  = 0;
  int      doneCount  = 0;
  expect_t sbQueue[$];

  column_tracer #(
    .NUM_COLUMNS (NUM_COLUMNS),
    .COL_W       (COL_W),
    .HEIGHT_W    (HEIGHT_W),
    .MAX_HEIGHT  (MAX_HEIGHT),
    .WORK_CYCLES (WORK_CYCLES),
    .RAMP_SHIFT  (RAMP_SHIFT),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .frame_start      (frame_start),
    .mode             (mode),
    .debug_set_height (debugSetHeight),
    .store_valid      (store_valid),
    .store_ready      (store_ready),
    .column           (column),
    .side             (side),
    .height           (height),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int clampHeight(input int raw);
    if (raw == 0) return 1;
    if (raw > MAX_HEIGHT) return MAX_HEIGHT;
    return raw;
  endfunction

  task automatic pushExpect(input int col, input int sd, input int ht, input longint when);
    expect_t e;
    e.col    = col;
    e.side   = sd;
    e.height = ht;
    e.cyc    = when;
    sbQueue.push_back(e);
  endtask

  // Pulses frame_start with the given mode/height; startCyc is the cycle it was high.
  task automatic applyStimulus(input logic [1:0] md, input logic [HEIGHT_W-1:0] ht, output longint startCyc);
    @(posedge clk);
    #1;
    enable         = 1'b1;
    mode           = md;
    debugSetHeight = ht;
    frame_start    = 1'b1;
    startCyc       = cyc;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  // which: 0 store_valid, 1 frame_done, 2 TRACE of column target, other: scoreboard drained.
  task automatic waitEvent(input int which, input int target, input int limit, input string tag);
    bit hit;
    int n;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = (store_valid === 1'b1);
        1:       hit = (frame_done === 1'b1);
        2:       hit = (busy === 1'b1) && (store_valid === 1'b0) && (column === COL_W'(target));
        default: hit = (sbQueue.size() == 0);
      endcase
    end
    checkOutput({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (reset_n && frame_done === 1'b1) doneCount++;
    if (reset_n && store_valid === 1'b1 && store_ready === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_store", 32'(store_valid), 32'd0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput($sformatf("col%0d_column", e.col), 32'(column), 32'(e.col));
        checkOutput($sformatf("col%0d_side", e.col), 32'(side), 32'(e.side));
        checkOutput($sformatf("col%0d_height", e.col), 32'(height), 32'(e.height));
        if (e.cyc >= 0) checkOutput($sformatf("col%0d_cycle", e.col), 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    longint      s;
    longint      a;
    int          base;
    bit          stable;
    logic [15:0] lfsrModel;

    #2;
    checkOutput("rst_valid", 32'(store_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_column", 32'(column), 32'd0);
    checkOutput("rst_side", 32'(side), 32'd0);
    checkOutput("rst_height", 32'(height), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n     = 1'b1;
    enable      = 1'b1;
    store_ready = 1'b1;

    $display("[TB] full FIXED frame, height 100");
    applyStimulus(MODE_FIXED, HEIGHT_W'(100), s);
    for (int c = 0; c < NUM_COLUMNS; c++) pushExpect(c, 0, 100, s + longint'(COL_PERIOD * (c + 1)));
    base = doneCount;
    waitEvent(1, 0, NUM_COLUMNS * COL_PERIOD + 20, "fixed_done");
    checkOutput("fixed_done_cycle", 32'(cyc - s), 32'(NUM_COLUMNS * COL_PERIOD + 1));
    repeat (4) @(negedge clk);
    checkOutput("fixed_done_once", 32'(doneCount - base), 32'd1);
    checkOutput("fixed_queue_drained", 32'(sbQueue.size()), 32'd0);
    checkOutput("fixed_idle_busy", 32'(busy), 32'd0);
    checkOutput("fixed_last_column", 32'(column), 32'(NUM_COLUMNS - 1));

    $display("[TB] full RAMP frame, height 230, mode input changed mid-frame");
    applyStimulus(MODE_RAMP, HEIGHT_W'(230), s);
    for (int c = 0; c < NUM_COLUMNS; c++)
      pushExpect(c, c % 2, clampHeight(230 + (c >> RAMP_SHIFT)), s + longint'(COL_PERIOD * (c + 1)));
    repeat (100) @(posedge clk);
    #1;
    mode = MODE_LFSR;
    base = doneCount;
    waitEvent(1, 0, NUM_COLUMNS * COL_PERIOD + 20, "ramp_done");
    repeat (3) @(negedge clk);
    checkOutput("ramp_done_once", 32'(doneCount - base), 32'd1);
    checkOutput("ramp_queue_drained", 32'(sbQueue.size()), 32'd0);

    $display("[TB] backpressure at column 5");
    applyStimulus(MODE_FIXED, HEIGHT_W'(77), s);
    for (int c = 0; c < 5; c++) pushExpect(c, 1, 77, s + longint'(COL_PERIOD * (c + 1)));
    pushExpect(5, 1, 77, -1);
    waitEvent(2, 5, 8 * COL_PERIOD, "stall_trace5");
    @(posedge clk);
    #1;
    store_ready = 1'b0;
    waitEvent(0, 0, 2 * COL_PERIOD, "stall_valid5");
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      stable &= (store_valid === 1'b1) && (column === COL_W'(5)) && (height === HEIGHT_W'(77)) &&
                (side === 1'b1) && (busy === 1'b1);
    end
    checkOutput("stall_hold_stable", 32'(stable), 32'd1);
    @(posedge clk);
    #1;
    store_ready = 1'b1;
    a = cyc;
    pushExpect(6, 1, 77, a + COL_PERIOD);
    waitEvent(3, 0, 3 * COL_PERIOD, "stall_col6_accepted");

    $display("[TB] enable dropped during STORE");
    @(posedge clk);
    #1;
    store_ready = 1'b0;
    waitEvent(0, 0, 2 * COL_PERIOD, "drop_valid7");
    checkOutput("drop_col7", 32'(column), 32'd7);
    base = doneCount;
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(negedge clk);
    checkOutput("drop_valid_same_cycle", 32'(store_valid), 32'd1);
    @(negedge clk);
    checkOutput("drop_valid_next", 32'(store_valid), 32'd0);
    checkOutput("drop_busy_next", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("ignored_start_busy", 32'(busy), 32'd0);
    checkOutput("drop_no_done", 32'(doneCount - base), 32'd0);
    @(posedge clk);
    #1;
    store_ready = 1'b1;
    enable      = 1'b1;

    $display("[TB] FIXED height 0 skip frame with restart at column 300");
    applyStimulus(MODE_FIXED, HEIGHT_W'(0), s);
    base = doneCount;
    waitEvent(2, 300, 302 * WORK_CYCLES, "skip_trace300");
    applyStimulus(MODE_FIXED, HEIGHT_W'(0), s);
    @(negedge clk);
    checkOutput("abort_column0", 32'(column), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd1);
    checkOutput("abort_no_done", 32'(doneCount - base), 32'd0);
    waitEvent(1, 0, NUM_COLUMNS * WORK_CYCLES + 20, "skip_done");
    checkOutput("skip_done_cycle", 32'(cyc - s), 32'(NUM_COLUMNS * WORK_CYCLES + 1));
    repeat (3) @(negedge clk);
    checkOutput("skip_done_once", 32'(doneCount - base), 32'd1);

    $display("[TB] asynchronous reset mid-TRACE");
    applyStimulus(MODE_FIXED, HEIGHT_W'(100), s);
    for (int c = 0; c < 2; c++) pushExpect(c, 0, 100, s + longint'(COL_PERIOD * (c + 1)));
    waitEvent(2, 2, 4 * COL_PERIOD, "rst_trace2");
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(store_valid), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_done", 32'(frame_done), 32'd0);
    checkOutput("async_rst_column", 32'(column), 32'd0);
    checkOutput("async_rst_side", 32'(side), 32'd0);
    checkOutput("async_rst_height", 32'(height), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] LFSR sequence from seed, repeated after reset");
    for (int run = 0; run < 2; run++) begin
      lfsrModel = SEED;
      applyStimulus(MODE_LFSR, HEIGHT_W'(0), s);
      for (int c = 0; c < 6; c++) begin
        pushExpect(c, int'(lfsrModel[15]), clampHeight(int'(lfsrModel[HEIGHT_W-1:0])),
                   s + longint'(COL_PERIOD * (c + 1)));
        lfsrModel = {lfsrModel[14:0], lfsrModel[15] ^ lfsrModel[13] ^ lfsrModel[12] ^ lfsrModel[10]};
      end
      waitEvent(3, 0, 8 * COL_PERIOD, $sformatf("lfsr_run%0d", run));
      @(posedge clk);
      #1;
      enable = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
    end

    repeat (2) @(negedge clk);
    checkOutput("final_queue_empty", 32'(sbQueue.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/column_tracer.md
Name: column_tracer

Overview:
- Parametrised per-column trace engine; successor to the fixed-rate dummy tracer.
- On each frame request it walks columns 0..NUM_COLUMNS-1. Each column takes a programmable "work" period, then the block presents a (column, side, height) result to the row/column store over a valid/ready handshake.
- Adds selectable synthetic height patterns, height clamping, backpressure, frame abort/restart and a frame-done pulse.
- Sits between the frame timing logic and the trace-result buffer.

Parameters:
- NUM_COLUMNS, 640, columns traced per frame (>=2).
- COL_W, 10, column bus width; must satisfy 2**COL_W >= NUM_COLUMNS.
- HEIGHT_W, 8, height bus width.
- MAX_HEIGHT, 240, clamp ceiling for height (1..2**HEIGHT_W-1).
- WORK_CYCLES, 32, cycles spent in TRACE per column (>=1).
- RAMP_SHIFT, 2, right-shift applied to column in RAMP mode.
- LFSR_SEED, 16'hACE1, reset value of pattern LFSR (non-zero).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  block enable; low forces IDLE immediately
- frame_start  in  1  single-cycle request to begin (or restart) a frame
- mode  in  2  pattern select: 0 FIXED, 1 RAMP, 2 LFSR, 3 reserved (acts as FIXED)
- debug_set_height  in  HEIGHT_W  base height for FIXED/RAMP modes
- store_valid  out  1  result valid
- store_ready  in  1  consumer accepts result
- column  out  COL_W  column index of current result
- side  out  1  wall side flag of current result
- height  out  HEIGHT_W  result height, always 1..MAX_HEIGHT when store_valid
- busy  out  1  high in TRACE or STORE
- frame_done  out  1  one-cycle pulse after last column accepted

Behaviour:
- States: IDLE, TRACE, STORE, DONE.
- Reset (reset_n low, async): state IDLE; store_valid=0, busy=0, frame_done=0, column=0, side=0, height=0; work counter 0; mode latch 0; LFSR=LFSR_SEED.
- IDLE: frame_start && enable -> TRACE next cycle. Set column=0, load work counter with WORK_CYCLES-1, latch mode.
- TRACE: counter decrements each cycle. At counter==0, compute result into output regs and go to STORE. TRACE therefore lasts exactly WORK_CYCLES cycles.
- Result compute (at end of TRACE), raw width HEIGHT_W+COL_W:
  - FIXED: raw=debug_set_height; side=debug_set_height[0].
  - RAMP: raw=debug_set_height+(column>>RAMP_SHIFT); side=column[0].
  - LFSR: raw=lfsr[HEIGHT_W-1:0]; side=lfsr[15]. LFSR (x^16+x^14+x^13+x^11) advances once per column, at TRACE exit only. It is not reset by frame_start.
  - Clamp: raw==0 -> 1; raw>MAX_HEIGHT -> MAX_HEIGHT.
  - Exception: FIXED with debug_set_height==0 skips the column. No STORE; advance directly as if accepted. This also applies at the last column, where the block goes to DONE.
- STORE: store_valid=1. column/side/height are held stable until store_valid && store_ready.
  - On acceptance, if column==NUM_COLUMNS-1 -> DONE.
  - Otherwise column+1, reload counter, -> TRACE.
  - store_ready low stalls indefinitely with no data change.
- DONE: frame_done=1 for exactly one cycle -> IDLE. column holds last value.
- Latency: frame_start at cycle 0 -> store_valid first high at cycle WORK_CYCLES+1. With store_ready tied high, one column every WORK_CYCLES+1 cycles; frame = NUM_COLUMNS*(WORK_CYCLES+1) cycles, plus 1 cycle for DONE.
- busy=1 in TRACE and STORE only.
- frame_start in TRACE/STORE/DONE (enable high): abort and restart at column 0, TRACE. store_valid drops the next cycle; no frame_done for the aborted frame. A frame_start in DONE takes priority over the return to IDLE.
- enable low in any state: next cycle IDLE, store_valid=0, busy=0, no frame_done. frame_start is ignored while enable is low.
- mode changes mid-frame have no effect until the next frame_start. debug_set_height is sampled at every TRACE exit.

Decomposition:
- Package tracer_pkg holds:
  - mode encodings (MODE_FIXED, MODE_RAMP, MODE_LFSR);
  - state enum;
  - LFSR tap mask and default seed.
- Sub-module tracer_pattern_gen contains the LFSR register plus the combinational raw-height/side selection and clamp, with an advance strobe input.
- FSM, counters and handshake stay in column_tracer.

Test Plan:
- Default params, FIXED, debug_set_height=100, store_ready=1, frame_start pulse -> first store_valid at cycle 33, column=0, height=100, side=0. 640 stores spaced 33 cycles apart, then frame_done pulse exactly once.
- RAMP, debug_set_height=230, RAMP_SHIFT=2 -> column 8 height=232, column 40 height=240, column 600 height=240 (clamped). side alternates with column[0].
- FIXED, debug_set_height=0 -> no store_valid for the whole frame; frame_done pulses after 640*32 cycles.
- STORE with store_ready held low 50 cycles at column 5 -> column/height/side stable, busy=1; release -> column 6 valid 33 cycles later.
- frame_start asserted during column 300 TRACE -> restart at column 0, no frame_done. enable dropped mid-STORE -> store_valid=0 next cycle, IDLE.
- reset_n asserted asynchronously mid-TRACE (between clock edges) -> all outputs 0 immediately. LFSR mode after reset reproduces an identical height sequence starting from LFSR_SEED.
